// File: rtl/alu_pkg.sv
// Shared types and the single-cycle result/flag function for alu_pipe.
package alu_pkg;

    localparam int unsigned MAX_W = 64;

    typedef logic [MAX_W-1:0] word_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRL = 4'd6,
        OP_SRA = 4'd7,
        OP_MUL = 4'd8
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic negative;
        logic overflow;
        logic zero;
        logic carry;
        logic illegal;
    } alu_flags_t;

    typedef struct packed {
        word_t      data;
        alu_flags_t flags;
    } alu_res_t;

    // Result and flags for every opcode except MUL, on operands zero-extended to MAX_W; w is the live width.
    function automatic alu_res_t alu_comb(input opcode_t op, input word_t a, input word_t b,
                                          input int unsigned w);
        alu_res_t           res;
        word_t              mask;
        word_t              msb;
        word_t              sh;
        word_t              ax;
        logic [MAX_W:0]     sum;
        logic               sa;
        logic               sb;
        logic               sr;
        mask = (word_t'(1) << w) - word_t'(1);
        msb  = word_t'(1) << (w - 1);
        sh   = b & (word_t'(w) - word_t'(1));
        sa   = |(a & msb);
        sb   = |(b & msb);
        ax   = a | (sa ? ~mask : '0);
        sum  = '0;
        res  = '0;
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                res.data = sum[MAX_W-1:0] & mask;
                res.flags.carry = |(sum >> w);
                sr = |(res.data & msb);
                res.flags.overflow = (sa == sb) && (sr != sa);
            end
            OP_SUB: begin
                res.data = (a - b) & mask;
                res.flags.carry = (a >= b);
                sr = |(res.data & msb);
                res.flags.overflow = (sa != sb) && (sr != sa);
            end
            OP_AND: res.data = a & b;
            OP_OR:  res.data = a | b;
            OP_XOR: res.data = a ^ b;
            OP_SLL: begin
                res.data = (a << sh) & mask;
                res.flags.carry = (sh != '0) && |(a & (msb >> (sh - word_t'(1))));
            end
            OP_SRL: begin
                res.data = a >> sh;
                res.flags.carry = (sh != '0) && |(a & (word_t'(1) << (sh - word_t'(1))));
            end
            OP_SRA: begin
                res.data = word_t'($signed(ax) >>> sh) & mask;
                res.flags.carry = (sh != '0) && |(a & (word_t'(1) << (sh - word_t'(1))));
            end
            OP_MUL: res.data = '0;
            default: res.flags.illegal = 1'b1;
        endcase
        res.flags.negative = |(res.data & msb);
        res.flags.zero     = (res.data == '0);
        return res;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Radix-2 shift-add unsigned multiplier: one partial product per cycle, DATA_W cycles per start.
module alu_mul_seq #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = $clog2(DATA_W)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  done_c,
    output logic [2*DATA_W-1:0]   product_c,
    output logic [2*DATA_W-1:0]   product
);

    localparam int unsigned P_W = 2 * DATA_W;

    logic              busy_q,   busy_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [P_W-1:0]    mcand_q,  mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [P_W-1:0]    acc_q,    acc_d;
    logic [P_W-1:0]    step_acc;

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = P_W'(a);
            mplier_d = b;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = step_acc;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    // product_c is the finished product during the last step; product holds it afterwards.
    assign done_c    = busy_q && (cnt_q == CNT_W'(DATA_W - 1));
    assign product_c = step_acc;
    assign product   = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops load the output register on acceptance; MUL runs on alu_mul_seq.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  opcode_t           in_opcode,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_negative,
    output logic              out_overflow,
    output logic              out_zero,
    output logic              out_carry,
    output logic              out_illegal
);

    localparam int unsigned SH_W = $clog2(DATA_W);

    typedef logic [DATA_W-1:0] data_t;

    state_t                state_q,     state_d;
    logic                  out_valid_q, out_valid_d;
    data_t                 out_data_q,  out_data_d;
    alu_flags_t            flags_q,     flags_d;

    logic                  out_free_c;
    logic                  mul_start_c;
    logic                  mul_done_c;
    logic [2*DATA_W-1:0]   mul_product_c;
    logic [2*DATA_W-1:0]   mul_product;
    logic [2*DATA_W-1:0]   prod_sel_c;
    data_t                 mul_data_c;
    alu_flags_t            mul_flags_c;
    alu_res_t              comb_res_c;

    assign out_free_c = !out_valid_q || out_ready;
    assign in_ready   = (state_q == ST_IDLE) && out_free_c;
    assign comb_res_c = alu_comb(in_opcode, word_t'(in_a), word_t'(in_b), DATA_W);

    alu_mul_seq #(
        .DATA_W (DATA_W),
        .CNT_W  (SH_W)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start     (mul_start_c),
        .a         (in_a),
        .b         (in_b),
        .done_c    (mul_done_c),
        .product_c (mul_product_c),
        .product   (mul_product)
    );

    // In WAIT the finished product has already been captured inside the multiplier.
    always_comb begin
        prod_sel_c           = (state_q == ST_WAIT) ? mul_product : mul_product_c;
        mul_data_c           = prod_sel_c[DATA_W-1:0];
        mul_flags_c          = '0;
        mul_flags_c.negative = mul_data_c[DATA_W-1];
        mul_flags_c.overflow = |prod_sel_c[2*DATA_W-1:DATA_W];
        mul_flags_c.zero     = (mul_data_c == '0);
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        flags_d     = flags_q;
        mul_start_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    if (in_opcode == OP_MUL) begin
                        mul_start_c = 1'b1;
                        state_d     = ST_MUL;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = DATA_W'(comb_res_c.data);
                        flags_d     = comb_res_c.flags;
                    end
                end
            end
            ST_MUL: begin
                if (mul_done_c) begin
                    if (out_free_c) begin
                        out_valid_d = 1'b1;
                        out_data_d  = mul_data_c;
                        flags_d     = mul_flags_c;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (out_free_c) begin
                    out_valid_d = 1'b1;
                    out_data_d  = mul_data_c;
                    flags_d     = mul_flags_c;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_negative = flags_q.negative;
    assign out_overflow = flags_q.overflow;
    assign out_zero     = flags_q.zero;
    assign out_carry    = flags_q.carry;
    assign out_illegal  = flags_q.illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (DATA_W = 8): integer-arithmetic reference model, in-order scoreboard, directed and random traffic.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    opcode_t      in_opcode = OP_ADD;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_negative, out_overflow, out_zero, out_carry, out_illegal;
    logic [4:0]   dut_f;

    logic rand_rdy = 1'b0;
    logic rnd_bit  = 1'b1;
    logic dir_rdy  = 1'b1;

    typedef struct {
        logic [7:0] d;
        logic [4:0] f;   // {N, V, Z, C, illegal}
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    assign out_ready = rand_rdy ? rnd_bit : dir_rdy;
    assign dut_f     = {out_negative, out_overflow, out_zero, out_carry, out_illegal};

    alu_pipe #(.DATA_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_negative (out_negative),
        .out_overflow (out_overflow),
        .out_zero     (out_zero),
        .out_carry    (out_carry),
        .out_illegal  (out_illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(posedge clk);
        #1;
        rnd_bit = ($urandom % 4) != 0;
    end

    // Reference: plain integer arithmetic on 8-bit values.
    function automatic exp_t ref_alu(input int op, input int a, input int b);
        exp_t e;
        int r, full, sa, sb, sh;
        bit c, v, il;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        sh = b % 8;
        c = 0; v = 0; il = 0; r = 0;
        case (op)
            0: begin full = a + b; r = full % 256; c = full > 255;
                     v = (sa + sb > 127) || (sa + sb < -128); end
            1: begin r = (a - b + 256) % 256; c = a >= b;
                     v = (sa - sb > 127) || (sa - sb < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin full = a << sh; r = full % 256; c = (sh != 0) && (((full >> 8) & 1) == 1); end
            6: begin r = a >> sh; c = (sh != 0) && (((a >> (sh - 1)) & 1) == 1); end
            7: begin r = (sa >>> sh) & 255; c = (sh != 0) && (((sa >>> (sh - 1)) & 1) == 1); end
            8: begin full = a * b; r = full % 256; v = full > 255; end
            default: begin r = 0; il = 1; end
        endcase
        e.d = 8'(r);
        e.f = {r >= 128, v, r == 0, c, il};
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, need 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard: accepted ops enter in order; every drained result is checked; stalled outputs must hold.
    logic        hold_prev = 1'b0;
    logic [12:0] snap = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", 32'(out_valid), 32'(1));
                chk("hold_stable", 32'({out_data, dut_f}), 32'(snap));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 32'(1), 32'(0));
                end else begin
                    e = q.pop_front();
                    chk("result", 32'({out_data, dut_f}), 32'({e.d, e.f}));
                end
            end
            if (in_valid && in_ready)
                q.push_back(ref_alu(int'(in_opcode), int'(in_a), int'(in_b)));
            hold_prev = out_valid && !out_ready;
            snap      = {out_data, dut_f};
        end
    end

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bit acc;
        int n;
        in_valid  = 1'b1;
        in_opcode = opcode_t'(op);
        in_a      = a;
        in_b      = b;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        in_valid = 1'b0;
        if (!acc) chk("issue_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_out(input int budget);
        int n;
        @(negedge clk);
        n = 0;
        while (!out_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("out_timeout", 32'(0), 32'(1));
    endtask

    task automatic do_lit(input string nm, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] ed, input logic [4:0] ef);
        exp_t e;
        e = ref_alu(int'(op), int'(a), int'(b));
        chk({nm, "_model"}, 32'({e.d, e.f}), 32'({ed, ef}));
        issue(op, a, b);
        wait_out(40);
        chk(nm, 32'({out_data, dut_f}), 32'({ed, ef}));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t0, n, lowcnt;

        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out", 32'({out_data, dut_f}), 32'(0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        do_lit("add_7f_01", 4'd0, 8'h7F, 8'h01, 8'h80, 5'b11000);
        t0 = cyc;
        for (int i = 0; i < 4; i++) issue(4'd0, 8'(i * 33), 8'(i * 70));
        chk("add_throughput", 32'(cyc - t0), 32'(4));
        wait_out(4);
        @(posedge clk); #1;

        do_lit("sub_00_01", 4'd1, 8'h00, 8'h01, 8'hFF, 5'b10000);
        do_lit("sub_05_05", 4'd1, 8'h05, 8'h05, 8'h00, 5'b00110);
        do_lit("sll_81_1",  4'd5, 8'h81, 8'h01, 8'h02, 5'b00010);
        do_lit("sra_80_3",  4'd7, 8'h80, 8'h03, 8'hF0, 5'b10000);
        do_lit("srl_01_0",  4'd6, 8'h01, 8'h00, 8'h01, 5'b00000);
        do_lit("mul_03_05", 4'd8, 8'h03, 8'h05, 8'h0F, 5'b00000);
        do_lit("illegal_f", 4'hF, 8'h12, 8'h34, 8'h00, 5'b00101);

        // MUL latency and in_ready low window
        issue(4'd8, 8'h10, 8'h10);
        n = 0; lowcnt = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            if (!in_ready) lowcnt++;
            n++;
            @(negedge clk);
        end
        chk("mul_latency", 32'(n), 32'(8));
        chk("mul_ready_low", 32'(lowcnt), 32'(8));
        chk("mul_10_10", 32'({out_data, dut_f}), 32'({8'h00, 5'b01100}));
        @(posedge clk); #1;

        // Backpressure: ADD held, MUL blocked until the consumer drains
        dir_rdy = 1'b0;
        issue(4'd0, 8'h20, 8'h22);
        fork
            issue(4'd8, 8'h07, 8'h09);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_in_ready", 32'(in_ready), 32'(0));
                    chk("bp_add_held", 32'({out_data, dut_f}), 32'({8'h42, 5'b00000}));
                end
                @(posedge clk); #1;
                dir_rdy = 1'b1;
            end
        join
        dir_rdy = 1'b0;
        wait_out(40);
        chk("bp_mul", 32'({out_data, dut_f}), 32'({8'h3F, 5'b00000}));
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        dir_rdy = 1'b1;
        @(posedge clk); #1;

        // Random traffic under random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 250; i++) begin
            int op;
            logic [7:0] a, b;
            op = (($urandom % 4) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
            a = 8'($urandom);
            b = (($urandom % 6) == 0) ? a : 8'($urandom);
            issue(4'(op), a, b);
            repeat ($urandom % 2) begin @(posedge clk); #1; end
        end
        rand_rdy = 1'b0;
        dir_rdy  = 1'b1;
        repeat (20) @(negedge clk);
        chk("drain_empty", 32'(q.size()), 32'(0));
        @(posedge clk); #1;

        // Reset in the middle of a MUL
        issue(4'd8, 8'h03, 8'h05);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        #1;
        chk("rst_mul_in_ready", 32'(in_ready), 32'(1));
        chk("rst_mul_out_valid", 32'(out_valid), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("rst_no_stale", 32'(out_valid), 32'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish, got cycle %0d, need < 100000", cyc);
        $fatal(1);
    end

endmodule
